// File: rtl/calc_core.sv
`default_nettype none
// ============================================================================
//  Module   : calc_core
//  Purpose  : Calculator control and datapath stage that sits after the key
//             decoder. It builds decimal operands from digit keys, applies the
//             selected operator on Enter and registers the value to display.
//             Add, subtract and multiply finish in one compute cycle. Divide
//             uses a restoring divider that produces one quotient bit per
//             cycle.
//  Ports    : clk           - system clock, rising edge
//             rst           - asynchronous reset, active low
//             rx_data       - 4-bit key code (0-9 digits, A-D operators)
//             rx_valid      - one-cycle key strobe qualifying all flags
//             is_digit      - key is a digit
//             is_operator   - key is an operator (A add, B sub, C mul, D div)
//             is_enter      - evaluate
//             is_clear      - clear everything
//             display_val   - registered value currently shown
//             result_valid  - one-cycle pulse when a new result is loaded
//             err           - error indicator, held until Clear
//             busy          - high while a computation is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module calc_core #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rx_data,
  input  logic             rx_valid,
  input  logic             is_digit,
  input  logic             is_operator,
  input  logic             is_enter,
  input  logic             is_clear,
  output logic [WIDTH-1:0] display_val,
  output logic             result_valid,
  output logic             err,
  output logic             busy
);

  localparam int CW  = $clog2(MAX_DIGITS + 1);
  localparam int DCW = $clog2(WIDTH) + 1;

  localparam logic [CW-1:0]  C_MAX_DIGITS = CW'(MAX_DIGITS);
  localparam logic [DCW-1:0] C_DIV_LAST   = DCW'(WIDTH - 1);

  localparam logic [2:0] ST_OPA    = 3'd0;
  localparam logic [2:0] ST_OPB    = 3'd1;
  localparam logic [2:0] ST_CALC   = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic [2:0]       state_q,   state_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic [1:0]       op_q,      op_d;
  logic [CW-1:0]    count_a_q, count_a_d;
  logic [CW-1:0]    count_b_q, count_b_d;
  logic [WIDTH-1:0] display_q, display_d;
  logic             rv_q,      rv_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic [WIDTH-1:0] quot_q,    quot_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;

  logic             w_digit, w_oper, w_enter, w_clear;
  logic [1:0]       w_op_code;
  logic [WIDTH-1:0] w_digit_val;
  logic [WIDTH-1:0] w_a_mac, w_b_mac;
  logic [2*WIDTH-1:0] w_sum, w_prod;
  logic [WIDTH:0]   w_shift;
  logic             w_trial_ok;
  logic [WIDTH-1:0] w_trial_diff;
  logic [WIDTH-1:0] w_quot_next;

  assign w_clear = rx_valid & is_clear;
  assign w_digit = rx_valid & is_digit;
  assign w_oper  = rx_valid & is_operator;
  assign w_enter = rx_valid & is_enter;

  // Codes A..D map to 0..3: low two bits plus two wraps 10,11,00,01 -> 0..3.
  assign w_op_code   = rx_data[1:0] + 2'd2;
  assign w_digit_val = WIDTH'(rx_data);

  assign w_a_mac = a_q * WIDTH'(10) + w_digit_val;
  assign w_b_mac = b_q * WIDTH'(10) + w_digit_val;

  assign w_sum  = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
  assign w_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Restoring divide step: shift in the next dividend bit and trial-subtract.
  // The partial remainder is always below the divisor, so the difference
  // fits in WIDTH bits whenever the trial succeeds.
  assign w_shift      = {rem_q, quot_q[WIDTH-1]};
  assign w_trial_ok   = (w_shift >= {1'b0, b_q});
  assign w_trial_diff = w_shift[WIDTH-1:0] - b_q;
  assign w_quot_next  = {quot_q[WIDTH-2:0], w_trial_ok};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    op_d      = op_q;
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    rv_d      = 1'b0;
    rem_d     = rem_q;
    quot_d    = quot_q;
    div_cnt_d = div_cnt_q;

    if (w_clear) begin
      state_d   = ST_OPA;
      a_d       = '0;
      b_d       = '0;
      result_d  = '0;
      op_d      = OP_ADD;
      count_a_d = '0;
      count_b_d = '0;
      rem_d     = '0;
      quot_d    = '0;
      div_cnt_d = '0;
    end else begin
      case (state_q)
        ST_OPA: begin
          if (w_digit) begin
            if (count_a_q < C_MAX_DIGITS) begin
              a_d       = w_a_mac;
              count_a_d = count_a_q + CW'(1);
            end
          end else if (w_oper) begin
            op_d      = w_op_code;
            b_d       = '0;
            count_b_d = '0;
            state_d   = ST_OPB;
          end else if (w_enter) begin
            result_d = a_q;
            rv_d     = 1'b1;
            state_d  = ST_RESULT;
          end
        end

        ST_OPB: begin
          if (w_digit) begin
            if (count_b_q < C_MAX_DIGITS) begin
              b_d       = w_b_mac;
              count_b_d = count_b_q + CW'(1);
            end
          end else if (w_oper) begin
            if (count_b_q == '0) op_d = w_op_code;
          end else if (w_enter) begin
            if (count_b_q != '0) begin
              state_d   = ST_CALC;
              rem_d     = '0;
              quot_d    = a_q;
              div_cnt_d = '0;
            end
          end
        end

        ST_CALC: begin
          case (op_q)
            OP_ADD: begin
              if (w_sum[2*WIDTH-1:WIDTH] != '0) begin
                state_d = ST_ERR;
              end else begin
                result_d = w_sum[WIDTH-1:0];
                rv_d     = 1'b1;
                state_d  = ST_RESULT;
              end
            end
            OP_SUB: begin
              if (b_q > a_q) begin
                state_d = ST_ERR;
              end else begin
                result_d = a_q - b_q;
                rv_d     = 1'b1;
                state_d  = ST_RESULT;
              end
            end
            OP_MUL: begin
              if (w_prod[2*WIDTH-1:WIDTH] != '0) begin
                state_d = ST_ERR;
              end else begin
                result_d = w_prod[WIDTH-1:0];
                rv_d     = 1'b1;
                state_d  = ST_RESULT;
              end
            end
            default: begin
              if (b_q == '0) begin
                state_d = ST_ERR;
              end else begin
                rem_d  = w_trial_ok ? w_trial_diff : w_shift[WIDTH-1:0];
                quot_d = w_quot_next;
                if (div_cnt_q == C_DIV_LAST) begin
                  result_d = w_quot_next;
                  rv_d     = 1'b1;
                  state_d  = ST_RESULT;
                end else begin
                  div_cnt_d = div_cnt_q + DCW'(1);
                end
              end
            end
          endcase
        end

        ST_RESULT: begin
          if (w_digit) begin
            a_d       = w_digit_val;
            count_a_d = CW'(1);
            state_d   = ST_OPA;
          end else if (w_oper) begin
            // Chaining: the result becomes operand A and is locked against
            // further digit entry.
            a_d       = result_q;
            count_a_d = C_MAX_DIGITS;
            op_d      = w_op_code;
            b_d       = '0;
            count_b_d = '0;
            state_d   = ST_OPB;
          end
        end

        default: begin
          state_d = ST_ERR;
        end
      endcase
    end

    case (state_d)
      ST_OPA:    display_d = a_d;
      ST_OPB:    display_d = (count_b_d != '0) ? b_d : a_d;
      ST_CALC:   display_d = display_q;
      ST_RESULT: display_d = result_d;
      default:   display_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_OPA;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      op_q      <= OP_ADD;
      count_a_q <= '0;
      count_b_q <= '0;
      display_q <= '0;
      rv_q      <= 1'b0;
      rem_q     <= '0;
      quot_q    <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      op_q      <= op_d;
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
      display_q <= display_d;
      rv_q      <= rv_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign display_val  = display_q;
  assign result_valid = rv_q;
  assign err          = (state_q == ST_ERR);
  assign busy         = (state_q == ST_CALC);

endmodule
`default_nettype wire

// File: tb/tb_calc_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_core
//  Purpose  : Directed self-checking bench for calc_core (WIDTH=16,
//             MAX_DIGITS=4) with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calc_core;

  logic        clk;
  logic        rst;
  logic [3:0]  rx_data;
  logic        rx_valid;
  logic        is_digit;
  logic        is_operator;
  logic        is_enter;
  logic        is_clear;
  logic [15:0] display_val;
  logic        result_valid;
  logic        err;
  logic        busy;

  int checks;
  int failures;

  calc_core #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .is_digit     (is_digit),
    .is_operator  (is_operator),
    .is_enter     (is_enter),
    .is_clear     (is_clear),
    .display_val  (display_val),
    .result_valid (result_valid),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one key for exactly one rising edge; returns 1 time unit after
  // that edge, i.e. at the first observation point of the following cycle.
  task automatic send_key(input logic [3:0] k);
    @(negedge clk);
    rx_data     = k;
    rx_valid    = 1'b1;
    is_digit    = (k <= 4'd9);
    is_operator = (k >= 4'hA) && (k <= 4'hD);
    is_enter    = (k == 4'hE);
    is_clear    = (k == 4'hF);
    @(posedge clk);
    #1;
    rx_valid    = 1'b0;
    is_digit    = 1'b0;
    is_operator = 1'b0;
    is_enter    = 1'b0;
    is_clear    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (display_val !== 16'd0) begin failures++; $display("FAIL reset_display actual=%0d expected=0", display_val); end
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_rv actual=%b expected=0", result_valid); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%b expected=0", err); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
  endtask

  task automatic test_add();
    send_key(4'd1);
    send_key(4'd2);
    checks++;
    if (display_val !== 16'd12) begin failures++; $display("FAIL add_opa_display actual=%0d expected=12", display_val); end
    send_key(4'hA);
    checks++;
    if (display_val !== 16'd12) begin failures++; $display("FAIL add_op_display actual=%0d expected=12", display_val); end
    send_key(4'd3);
    send_key(4'd4);
    checks++;
    if (display_val !== 16'd34) begin failures++; $display("FAIL add_opb_display actual=%0d expected=34", display_val); end
    send_key(4'hE);
    checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      failures++; $display("FAIL add_t1 busy=%b rv=%b expected busy=1 rv=0", busy, result_valid);
    end
    step();
    checks++;
    if (result_valid !== 1'b1 || busy !== 1'b0 || display_val !== 16'd46) begin
      failures++; $display("FAIL add_t2 rv=%b busy=%b display=%0d expected rv=1 busy=0 display=46", result_valid, busy, display_val);
    end
    step();
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL add_rv_pulse actual=%b expected=0", result_valid); end
  endtask

  task automatic test_mul_overflow();
    send_key(4'hF);
    for (int i = 0; i < 4; i++) send_key(4'd9);
    send_key(4'hC);
    for (int i = 0; i < 4; i++) send_key(4'd9);
    send_key(4'hE);
    step();
    checks++;
    if (err !== 1'b1 || display_val !== 16'd0) begin
      failures++; $display("FAIL mul_ovf err=%b display=%0d expected err=1 display=0", err, display_val);
    end
    send_key(4'd5);
    send_key(4'hE);
    checks++;
    if (err !== 1'b1 || display_val !== 16'd0 || result_valid !== 1'b0) begin
      failures++; $display("FAIL err_hold err=%b display=%0d rv=%b expected err=1 display=0 rv=0", err, display_val, result_valid);
    end
    send_key(4'hF);
    checks++;
    if (err !== 1'b0 || display_val !== 16'd0) begin
      failures++; $display("FAIL err_clear err=%b display=%0d expected err=0 display=0", err, display_val);
    end
  endtask

  task automatic test_div();
    int n;
    send_key(4'hF);
    send_key(4'd1);
    send_key(4'd0);
    send_key(4'd0);
    send_key(4'hD);
    send_key(4'd7);
    send_key(4'hE);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL div_busy_cycles actual=%0d expected=16", n); end
    checks++;
    if (result_valid !== 1'b1 || display_val !== 16'd14) begin
      failures++; $display("FAIL div_result rv=%b display=%0d expected rv=1 display=14", result_valid, display_val);
    end
    // Divide by zero
    send_key(4'hF);
    send_key(4'd1);
    send_key(4'd0);
    send_key(4'hD);
    send_key(4'd0);
    send_key(4'hE);
    step();
    checks++;
    if (err !== 1'b1 || display_val !== 16'd0) begin
      failures++; $display("FAIL div_zero err=%b display=%0d expected err=1 display=0", err, display_val);
    end
  endtask

  task automatic test_sub_chain();
    send_key(4'hF);
    send_key(4'd5);
    send_key(4'hB);
    send_key(4'd8);
    send_key(4'hE);
    step();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL sub_underflow err=%b expected=1", err); end
    send_key(4'hF);
    send_key(4'd8);
    send_key(4'hB);
    send_key(4'd5);
    send_key(4'hE);
    step();
    checks++;
    if (display_val !== 16'd3 || result_valid !== 1'b1) begin
      failures++; $display("FAIL sub_result display=%0d rv=%b expected display=3 rv=1", display_val, result_valid);
    end
    send_key(4'hB);
    checks++;
    if (display_val !== 16'd3) begin failures++; $display("FAIL chain_display actual=%0d expected=3", display_val); end
    send_key(4'd1);
    send_key(4'hE);
    step();
    checks++;
    if (display_val !== 16'd2 || result_valid !== 1'b1) begin
      failures++; $display("FAIL chain_result display=%0d rv=%b expected display=2 rv=1", display_val, result_valid);
    end
  endtask

  task automatic test_digit_limit();
    send_key(4'hF);
    for (int i = 1; i <= 5; i++) send_key(4'(i));
    checks++;
    if (display_val !== 16'd1234) begin failures++; $display("FAIL digit_limit actual=%0d expected=1234", display_val); end
    send_key(4'hA);
    send_key(4'hA);
    send_key(4'hB);
    send_key(4'hE);
    checks++;
    if (busy !== 1'b0 || display_val !== 16'd1234) begin
      failures++; $display("FAIL enter_empty_b busy=%b display=%0d expected busy=0 display=1234", busy, display_val);
    end
    send_key(4'd6);
    checks++;
    if (display_val !== 16'd6) begin failures++; $display("FAIL opb_digit actual=%0d expected=6", display_val); end
    send_key(4'hE);
    step();
    checks++;
    if (display_val !== 16'd1228) begin failures++; $display("FAIL op_replace actual=%0d expected=1228", display_val); end
  endtask

  task automatic test_reset_mid_div();
    send_key(4'hF);
    send_key(4'd6);
    send_key(4'd5);
    send_key(4'd5);
    send_key(4'd3);
    send_key(4'd5);
    send_key(4'hD);
    send_key(4'd3);
    send_key(4'hE);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL div_running busy=%b expected=1", busy); end
    rst = 1'b0;
    #1;
    checks++;
    if (display_val !== 16'd0 || result_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL async_reset display=%0d rv=%b err=%b busy=%b expected all 0", display_val, result_valid, err, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    send_key(4'd7);
    send_key(4'hE);
    checks++;
    if (result_valid !== 1'b1 || display_val !== 16'd7) begin
      failures++; $display("FAIL post_reset_enter rv=%b display=%0d expected rv=1 display=7", result_valid, display_val);
    end
    step();
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL post_reset_pulse rv=%b expected=0", result_valid); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    rx_data     = 4'd0;
    rx_valid    = 1'b0;
    is_digit    = 1'b0;
    is_operator = 1'b0;
    is_enter    = 1'b0;
    is_clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_add();
    test_mul_overflow();
    test_div();
    test_sub_chain();
    test_digit_limit();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
